// File: rtl/control_read.sv
// Tile reader: collects one frame of AXI-stream beats into a row buffer, then
// replays row r of every tile in parallel toward the FFT lanes.
module control_read #(
  parameter int FFTSIZE = 8,
  parameter int DATALEN = 8,
  parameter int PARATIL = 9,
  parameter int INDXLEN = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                axi_invalid,
  output logic                                axi_inready,
  input  logic                                axi_inlast,
  input  logic [63:0]                         axi_indata,
  output logic [PARATIL-1:0]                  fftvalid,
  input  logic                                fftready,
  output logic                                fftlast,
  output logic [PARATIL*FFTSIZE*DATALEN-1:0]  fftdata,
  output logic                                frame_err
);

  localparam int ROWW  = FFTSIZE * DATALEN;
  localparam int DEPTH = PARATIL * FFTSIZE;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  // Handshake: a beat moves on a rising edge where axi_invalid && axi_inready;
  // a row moves on a rising edge where fftvalid && fftready. Neither side may
  // depend on the other's ready/valid combinationally.
  logic [1:0]         state_q, state_d;
  logic [INDXLEN-1:0] tile_q, tile_d;
  logic [INDXLEN-1:0] row_q, row_d;
  logic               err_q, err_d;
  logic [ROWW-1:0]    mem_q [DEPTH];

  logic          accept;
  logic          last_idx;
  logic          row_end;
  logic [AW-1:0] wr_idx;

  assign axi_inready = !rst && (state_q == S_IDLE || state_q == S_LOAD);
  assign accept      = axi_invalid && axi_inready;
  assign row_end     = (row_q == INDXLEN'(FFTSIZE - 1));
  assign last_idx    = (tile_q == INDXLEN'(PARATIL - 1)) && row_end;
  assign wr_idx      = AW'(tile_q) * AW'(FFTSIZE) + AW'(row_q);

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    row_d   = row_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (axi_inlast || last_idx) begin
            // Either terminator ends the frame; disagreement between them is a framing error.
            state_d = S_STREAM;
            tile_d  = '0;
            row_d   = '0;
            if (axi_inlast != last_idx) err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            if (row_end) begin
              row_d  = '0;
              tile_d = tile_q + INDXLEN'(1);
            end else begin
              row_d = row_q + INDXLEN'(1);
            end
          end
        end
      end
      S_STREAM: begin
        if (fftready) begin
          if (row_end) begin
            state_d = S_IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + INDXLEN'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tile_d  = '0;
        row_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  // The first beat of a frame clears the whole buffer so short frames read zeros.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state_q == S_IDLE) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end
      mem_q[wr_idx] <= axi_indata[ROWW-1:0];
    end
  end

  always_comb begin
    fftdata = '0;
    if (state_q == S_STREAM) begin
      for (int t = 0; t < PARATIL; t++) begin
        fftdata[t*ROWW +: ROWW] = mem_q[AW'(t * FFTSIZE) + AW'(row_q)];
      end
    end
  end

  assign fftvalid  = {PARATIL{state_q == S_STREAM}};
  assign fftlast   = (state_q == S_STREAM) && row_end;
  assign frame_err = err_q;

endmodule

// File: tb/tb_control_read.sv
// Directed bench for control_read: full, throttled, gapped, short, reset-aborted
// and unterminated frames, each checked row by row against a byte-pattern model.
module tb_control_read;

  localparam int W = 576;

  logic          clk;
  logic          rst;
  logic          axi_invalid;
  logic          axi_inready;
  logic          axi_inlast;
  logic [63:0]   axi_indata;
  logic [8:0]    fftvalid;
  logic          fftready;
  logic          fftlast;
  logic [W-1:0]  fftdata;
  logic          frame_err;

  int checks;
  int errors;

  control_read dut (
    .clk         (clk),
    .rst         (rst),
    .axi_invalid (axi_invalid),
    .axi_inready (axi_inready),
    .axi_inlast  (axi_inlast),
    .axi_indata  (axi_indata),
    .fftvalid    (fftvalid),
    .fftready    (fftready),
    .fftlast     (fftlast),
    .fftdata     (fftdata),
    .frame_err   (frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Row r of every tile: sample byte = beat index t*8+r, zero if that beat never arrived.
  function automatic logic [W-1:0] exp_row(input int r, input int nrecv);
    logic [W-1:0] res;
    int b;
    res = '0;
    for (int t = 0; t < 9; t++) begin
      b = t * 8 + r;
      for (int k = 0; k < 8; k++) begin
        res[(t*8+k)*8 +: 8] = (b < nrecv) ? 8'(b) : 8'd0;
      end
    end
    return res;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inready"}, W'(axi_inready), W'(0));
    check({tag, "_valid"},   W'(fftvalid),    W'(0));
    check({tag, "_last"},    W'(fftlast),     W'(0));
    check({tag, "_data"},    fftdata,         W'(0));
    check({tag, "_err"},     W'(frame_err),   W'(0));
  endtask

  // driver: beats 0..nbeats-1, bytes = beat index, inlast on beat last_at
  task automatic send_frame(input int nbeats, input int last_at, input bit gaps, input bit expect_stream);
    int b;
    int budget;
    b = 0;
    budget = 0;
    while (b < nbeats && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (gaps && (budget % 2 == 0)) begin
        axi_invalid = 1'b0;
        axi_inlast  = 1'b0;
      end else begin
        axi_invalid = 1'b1;
        axi_indata  = {8{8'(b)}};
        axi_inlast  = (b == last_at);
        if (axi_inready) b++;
      end
    end
    if (b < nbeats) check("send_timeout", W'(b), W'(nbeats));
    if (expect_stream) begin
      check("pre_valid", W'(fftvalid), W'(0));
      @(negedge clk);
      axi_invalid = 1'b0;
      axi_inlast  = 1'b0;
      check("valid_rise", W'(fftvalid), W'(9'h1FF));
    end
  endtask

  // scoreboard side: consume 8 rows, compare each against the model
  task automatic collect(input int nrecv, input bit toggle, input bit exp_err);
    int r;
    int cyc;
    r = 0;
    cyc = 0;
    while (r < 8 && cyc < 200) begin
      check("fftvalid", W'(fftvalid), W'(9'h1FF));
      check("inready_stream", W'(axi_inready), W'(0));
      check($sformatf("row%0d", r), fftdata, exp_row(r, nrecv));
      check($sformatf("fftlast%0d", r), W'(fftlast), W'(r == 7));
      fftready    = toggle ? (cyc % 2 == 1) : 1'b1;
      axi_invalid = 1'b1;
      axi_indata  = '1;
      if (fftready) r++;
      cyc++;
      @(negedge clk);
    end
    axi_invalid = 1'b0;
    fftready    = 1'b0;
    check("row_count", W'(r), W'(8));
    check("valid_fall", W'(fftvalid), W'(0));
    check("idle_ready", W'(axi_inready), W'(1));
    check("frame_err", W'(frame_err), W'(exp_err));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    axi_invalid = 1'b0;
    axi_inlast  = 1'b0;
    axi_indata  = '0;
    fftready    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", W'(axi_inready), W'(1));

    send_frame(72, 71, 1'b0, 1'b1);
    collect(72, 1'b0, 1'b0);

    send_frame(72, 71, 1'b0, 1'b1);
    collect(72, 1'b1, 1'b0);

    send_frame(72, 71, 1'b1, 1'b1);
    collect(72, 1'b0, 1'b0);

    send_frame(40, 39, 1'b0, 1'b1);
    collect(40, 1'b0, 1'b1);

    // abort mid-load; frame_err from the short frame must also clear
    send_frame(31, 99, 1'b0, 1'b0);
    @(negedge clk);
    axi_invalid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", W'(axi_inready), W'(1));
    check("abort_valid", W'(fftvalid), W'(0));
    send_frame(72, 71, 1'b0, 1'b1);
    collect(72, 1'b0, 1'b0);

    send_frame(72, 99, 1'b0, 1'b1);
    collect(72, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_read.md
CONTROL_READ -- requirements
Module: control_read

Interface
REQ-001 Parameter FFTSIZE, default 8: tile edge length; samples per row and rows per tile.
REQ-002 Parameter DATALEN, default 8: bits per real input sample.
REQ-003 Parameter PARATIL, default 9: tiles per frame, all processed in parallel.
REQ-004 Parameter INDXLEN, default 6: width of internal beat/row counters.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port axi_invalid, input, 1: AXI-stream input beat valid.
REQ-008 Port axi_inready, output, 1: block accepts the beat this cycle.
REQ-009 Port axi_inlast, input, 1: final beat of frame.
REQ-010 Port axi_indata, input, 64: eight DATALEN-bit samples; bits [8k+7:8k] = column k.
REQ-011 Port fftvalid, output, PARATIL: per-tile row valid toward FFT.
REQ-012 Port fftready, input, 1: FFT accepts current row (common to all tiles).
REQ-013 Port fftlast, output, 1: current row is row FFTSIZE-1.
REQ-014 Port fftdata, output, PARATIL*FFTSIZE*DATALEN: tile t column k at bits [(t*FFTSIZE+k)*DATALEN +: DATALEN].
REQ-015 Port frame_err, output, 1: sticky framing-error flag.

Function
REQ-016 Frame = PARATIL*FFTSIZE beats (72 default); beat b writes tile b/FFTSIZE, row b%FFTSIZE of internal buffer.
REQ-017 Beat accepted only when axi_invalid && axi_inready in same cycle.
REQ-018 States: IDLE, LOAD, STREAM; single FSM.
REQ-019 IDLE: axi_inready=1, fftvalid=0; accepted beat stored as beat 0, -> LOAD.
REQ-020 LOAD: axi_inready=1; each accepted beat stored at next index; beat counter increments by 1.
REQ-021 On acceptance of final beat (index 71): -> STREAM next cycle, axi_inready=0 same edge.
REQ-022 Early axi_inlast (beat index < 71): frame_err set, unreceived rows zero-filled, -> STREAM.
REQ-023 axi_inlast low on beat 71: frame_err set, frame still streamed normally.
REQ-024 STREAM: axi_inready=0; fftvalid=all ones; fftdata = row r of every tile; r starts at 0.
REQ-025 Latency: fftvalid rises exactly one cycle after final beat acceptance.
REQ-026 fftdata, fftlast held stable while fftvalid && !fftready.
REQ-027 fftvalid && fftready: r increments; on r=FFTSIZE-1 accepted -> IDLE, fftvalid=0 next cycle.
REQ-028 fftlast=1 only while r=FFTSIZE-1 in STREAM.
REQ-029 No back-to-back overlap: next frame accepted only after return to IDLE (first IDLE cycle accepts).
REQ-030 axi_invalid ignored outside IDLE/LOAD; fftready ignored outside STREAM.
REQ-031 Buffer zero-filled at frame start so short frames never emit stale data.

Reset
REQ-032 rst high: state=IDLE, counters=0, fftvalid=0, fftlast=0, fftdata=0, axi_inready=0, frame_err=0.
REQ-033 axi_inready goes 1 the first cycle after rst deasserts.
REQ-034 rst mid-LOAD or mid-STREAM aborts frame; no partial output after release.
REQ-035 frame_err cleared only by rst.

Verification
REQ-036 72 beats, beat b bytes = b, last on 71, fftready=1 -> 8 rows; row r tile t all samples = t*8+r; fftlast on row 7; frame_err=0.
REQ-037 Same frame, fftready toggling 1/0 -> each row held while ready=0; 8 handshakes total; no duplicates/skips.
REQ-038 axi_inlast on beat 39 -> frame_err=1; tiles 0-4 rows correct; tiles 5-8 all zero.
REQ-039 axi_invalid gaps every other cycle -> fftvalid rises one cycle after 72nd accepted beat; data identical to REQ-036.
REQ-040 rst pulse after beat 30 -> outputs reset values; next full frame streams correctly, frame_err=0.
REQ-041 72 beats with axi_inlast never high -> frame_err=1, frame streamed with correct data.
